multi_cycle_sequencer: RTL
==========================

# multi_cycle_sequencer

Decode-stage sequencer that sits between the IF/ID register and the control unit and drives its `opCode` and `makeMeBubble` inputs. It expands two-part instructions (CALL, RET, RTI) into their first and second opcodes on consecutive cycles. It injects the two-part interrupt sequence at legal instruction boundaries and keeps LDM's immediate word from being decoded as an opcode. It also applies hazard-unit stalls and branch flushes, and gives the fetch stage a PC-hold request.

## Interface
- No parameters; opcode width is fixed at 5.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `fetchedOp` input 5: opcode field of the instruction word in IF/ID.
- `interrupt` input 1: external interrupt request, level-sampled every cycle.
- `stall` input 1: load-use stall request from the hazard unit.
- `flush` input 1: branch-taken flush from EX; kills the decode-stage instruction.
- `opCodeOut` output 5: opcode presented to the control unit.
- `makeMeBubble` output 1: forces a bubble in the control unit.
- `pcHold` output 1: freezes the PC and the IF/ID register this cycle.
- `intAck` output 1: one-cycle pulse when the interrupt sequence completes.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- Registers: 3-bit state and 1-bit `intPending`.
- States: IDLE, CALL2, RET2, RTI2, INT1, INT2, IMM.
- Outputs are combinational from the current state and inputs (Mealy). The next state is registered.
- Priority: `rst` > `flush` > `stall` > normal sequencing.
- `intPending`:
  - set on any cycle with `interrupt`=1;
  - cleared on the edge that enters INT1;
  - preserved across stall and flush.
- IDLE, `intPending`=1 and `fetchedOp` not in {11000, 11010, 11100, 10001}:
  - `opCodeOut`=11110, `pcHold`=1, next INT1.
  - The fetched instruction stays in IF/ID and is replayed after the handler returns.
- IDLE otherwise: `opCodeOut`=`fetchedOp`. Then by opcode:
  - 11000 → `pcHold`=1, next CALL2.
  - 11010 → `pcHold`=1, next RET2.
  - 11100 → `pcHold`=1, next RTI2.
  - 10001 (LDM) → `pcHold`=0, next IMM.
  - anything else → stay IDLE.
- CALL2 / RET2 / RTI2: `opCodeOut`=11001 / 11011 / 11101 respectively, `pcHold`=0, next IDLE. Interrupts are not taken in these states.
- INT1: `opCodeOut`=11111, `pcHold`=1, next INT2.
- INT2: `opCodeOut`=00000, `pcHold`=0, `intAck`=1, next IDLE. The pipeline redirects the PC to the vector via the 11111 path.
- IMM: `opCodeOut`=00000; the immediate word is consumed by the LDM datapath and never decoded. Next IDLE. Interrupts are blocked.
- `stall`=1 (no flush):
  - `makeMeBubble`=1, `pcHold`=1, `intAck`=0;
  - state holds;
  - `opCodeOut` keeps the value it would otherwise show.
- `flush`=1:
  - `opCodeOut`=00000, `makeMeBubble`=0, `pcHold`=0, `intAck`=0;
  - next IDLE from any state, so a partially issued CALL, RET or RTI second part is aborted;
  - `intPending` is kept.
- When none of the conditions above asserts a control output, it is 0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `intPending`=0.
- While `rst`=1: `opCodeOut`=00000, `makeMeBubble`=0, `pcHold`=0, `intAck`=0, `busy`=0.
- Latencies:
  - second-part opcode appears exactly 1 cycle after the first part (absent stall);
  - interrupt sequence is 3 cycles: 11110, 11111, NOP with `intAck`;
  - an interrupt raised in cycle N shows 11110 no earlier than cycle N+1.
- An interrupt arriving while CALL2, RET2, RTI2 or IMM is active is taken at the next IDLE cycle whose `fetchedOp` is legal.
- `stall` held for k cycles delays the sequence by exactly k cycles with no lost or duplicated opcodes.
- `flush` and `stall` asserted together: flush wins.
- Reset asserted mid-sequence: the sequence is abandoned immediately, with no second part and no `intAck`.

## Test plan
- Reset, then `fetchedOp`=01001 for 3 cycles → `opCodeOut`=01001 every cycle, `pcHold`=0, `busy`=0.
- `fetchedOp`=11000 → cycle 0: 11000 with `pcHold`=1; cycle 1: 11001 with `pcHold`=0; cycle 2: IDLE. Repeat for 11010→11011 and 11100→11101.
- `interrupt` pulse for 1 cycle while `fetchedOp`=00100 → next three cycles show 11110/`pcHold`=1, 11111/`pcHold`=1, then 00000/`intAck`=1. `intPending` is 0 afterwards.
- `interrupt` raised on the same cycle as `fetchedOp`=10001 → 10001, then 00000 (IMM), then 11110, 11111, 00000 with `intAck`=1.
- Issue 11000 with `stall`=1 in CALL2 for 2 cycles → 11001 held with `makeMeBubble`=1 and `pcHold`=1 for 2 cycles, then 11001 with bubble 0, then IDLE.
- `flush`=1 in CALL2 → `opCodeOut`=00000 and IDLE next cycle. `rst` asserted in INT1 → all outputs 0 immediately and no `intAck` is ever produced.

Source files
------------

// File: rtl/multi_cycle_sequencer.sv
// Decode-stage sequencer: expands CALL/RET/RTI into two opcodes, injects the
// two-part interrupt sequence, shields LDM immediates, and applies stall/flush.
module multi_cycle_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] fetchedOp,
    input  logic       interrupt,
    input  logic       stall,
    input  logic       flush,
    output logic [4:0] opCodeOut,
    output logic       makeMeBubble,
    output logic       pcHold,
    output logic       intAck,
    output logic       busy
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LDM   = 5'b10001;
    localparam logic [4:0] OP_CALL1 = 5'b11000;
    localparam logic [4:0] OP_CALL2 = 5'b11001;
    localparam logic [4:0] OP_RET1  = 5'b11010;
    localparam logic [4:0] OP_RET2  = 5'b11011;
    localparam logic [4:0] OP_RTI1  = 5'b11100;
    localparam logic [4:0] OP_RTI2  = 5'b11101;
    localparam logic [4:0] OP_INT1  = 5'b11110;
    localparam logic [4:0] OP_INT2  = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALL2 = 3'd1,
        S_RET2  = 3'd2,
        S_RTI2  = 3'd3,
        S_INT1  = 3'd4,
        S_INT2  = 3'd5,
        S_IMM   = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic       int_pending_q, int_pending_d;
    logic [4:0] op_d;
    logic       bubble_d, hold_d, ack_d;
    logic       int_blocked;

    // Interrupts may not split a multi-part instruction or an LDM/immediate pair.
    assign int_blocked = (fetchedOp == OP_CALL1) || (fetchedOp == OP_RET1) ||
                         (fetchedOp == OP_RTI1)  || (fetchedOp == OP_LDM);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        op_d     = OP_NOP;
        bubble_d = 1'b0;
        hold_d   = 1'b0;
        ack_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (int_pending_q && !int_blocked) begin
                    op_d    = OP_INT1;
                    hold_d  = 1'b1;
                    state_d = S_INT1;
                end else begin
                    op_d = fetchedOp;
                    case (fetchedOp)
                        OP_CALL1: begin hold_d = 1'b1; state_d = S_CALL2; end
                        OP_RET1:  begin hold_d = 1'b1; state_d = S_RET2;  end
                        OP_RTI1:  begin hold_d = 1'b1; state_d = S_RTI2;  end
                        OP_LDM:   state_d = S_IMM;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_CALL2: begin op_d = OP_CALL2; state_d = S_IDLE; end
            S_RET2:  begin op_d = OP_RET2;  state_d = S_IDLE; end
            S_RTI2:  begin op_d = OP_RTI2;  state_d = S_IDLE; end
            S_INT1:  begin op_d = OP_INT2;  hold_d = 1'b1; state_d = S_INT2; end
            S_INT2:  begin op_d = OP_NOP;   ack_d = 1'b1;  state_d = S_IDLE; end
            S_IMM:   begin op_d = OP_NOP;   state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase

        // Flush kills the decode slot outright; stall freezes it but keeps the opcode visible.
        if (flush) begin
            op_d     = OP_NOP;
            bubble_d = 1'b0;
            hold_d   = 1'b0;
            ack_d    = 1'b0;
            state_d  = S_IDLE;
        end else if (stall) begin
            bubble_d = 1'b1;
            hold_d   = 1'b1;
            ack_d    = 1'b0;
            state_d  = state_q;
        end

        int_pending_d = interrupt ||
                        (int_pending_q && !(state_q == S_IDLE && state_d == S_INT1));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_pending_q <= int_pending_d;
        end
    end

    always_comb begin
        opCodeOut    = rst ? OP_NOP : op_d;
        makeMeBubble = !rst && bubble_d;
        pcHold       = !rst && hold_d;
        intAck       = !rst && ack_d;
        busy         = !rst && (state_q != S_IDLE);
    end

endmodule
